// File: rtl/dist_pkg.sv
// Shared constants and the window buffer state encoding for the FMCW dist pipeline.
package dist_pkg;

    localparam int unsigned WB_N  = 1024;
    localparam int unsigned WB_DW = 14;

    typedef enum logic {
        WB_FILL  = 1'b0,
        WB_DRAIN = 1'b1
    } wb_state_e;

endpackage

// File: rtl/ram_sdp_reg.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// Only the output register is reset; the array contents are not cleared.
module ram_sdp_reg #(
    parameter int unsigned DW = 14,
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output holds its last value when no read is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/window_buffer.sv
// Frame buffer between FIR decimator and FFT: capture N samples, then replay them.
// Define WINDOW_BUFFER_BITREV_EN to replay in bit-reversed address order.
module window_buffer
    import dist_pkg::*;
#(
    parameter int unsigned N  = WB_N,
    parameter int unsigned DW = WB_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wren,
    input  logic [DW-1:0] wrdata,
    input  logic          rden,
    output logic [DW-1:0] rddata,
    output logic          rdvalid,
    output logic          rdlast,
    output logic          full,
    output logic          drained,
    output logic          overflow
);

    localparam int unsigned     AW   = $clog2(N);
    localparam logic [AW-1:0]   LAST = AW'(N - 1);

    wb_state_e     r_state, w_state_d;
    logic [AW-1:0] r_wr_ptr, w_wr_ptr_d;
    logic [AW-1:0] r_rd_ptr, w_rd_ptr_d;
    logic          r_rdvalid, r_rdlast, r_drained, r_overflow;
    logic          w_overflow_d;
    logic          w_wr_acc, w_rd_iss;
    logic [AW-1:0] w_rd_addr;

    assign w_wr_acc = (r_state == WB_FILL) && wren;
    assign w_rd_iss = (r_state == WB_DRAIN) && rden;

    always_comb begin
        w_state_d    = r_state;
        w_wr_ptr_d   = r_wr_ptr;
        w_rd_ptr_d   = r_rd_ptr;
        w_overflow_d = r_overflow;
        unique case (r_state)
            WB_FILL: begin
                if (wren) begin
                    w_wr_ptr_d = r_wr_ptr + 1'b1;
                    if (r_wr_ptr == LAST) begin
                        w_state_d = WB_DRAIN;
                    end
                end
            end
            WB_DRAIN: begin
                w_overflow_d = r_overflow | wren;
                if (rden) begin
                    w_rd_ptr_d = r_rd_ptr + 1'b1;
                    if (r_rd_ptr == LAST) begin
                        w_state_d = WB_FILL;
                    end
                end
            end
            default: w_state_d = WB_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= WB_FILL;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rdvalid  <= 1'b0;
            r_rdlast   <= 1'b0;
            r_drained  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_rdvalid  <= w_rd_iss;
            r_rdlast   <= w_rd_iss && (r_rd_ptr == LAST);
            r_drained  <= r_rdlast;
            r_overflow <= w_overflow_d;
        end
    end

`ifdef WINDOW_BUFFER_BITREV_EN
    always_comb begin
        w_rd_addr = '0;
        for (int i = 0; i < int'(AW); i++) begin
            w_rd_addr[i] = r_rd_ptr[int'(AW) - 1 - i];
        end
    end
`else
    assign w_rd_addr = r_rd_ptr;
`endif

    ram_sdp_reg #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wrdata),
        .i_rd_en   (w_rd_iss),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (rddata)
    );

    assign rdvalid  = r_rdvalid;
    assign rdlast   = r_rdlast;
    assign drained  = r_drained;
    assign overflow = r_overflow;
    assign full     = (r_state == WB_DRAIN);

endmodule

// File: tb/tb_window_buffer.sv
// Bench for window_buffer (N=8): frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_window_buffer;

    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int DW   = 14;

    logic          clk;
    logic          rst_n;
    logic          wren;
    logic [DW-1:0] wrdata;
    logic          rden;
    logic [DW-1:0] rddata;
    logic          rdvalid;
    logic          rdlast;
    logic          full;
    logic          drained;
    logic          overflow;

    window_buffer #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wren     (wren),
        .wrdata   (wrdata),
        .rden     (rden),
        .rddata   (rddata),
        .rdvalid  (rdvalid),
        .rdlast   (rdlast),
        .full     (full),
        .drained  (drained),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int lit [N];

    // Frame-level reference model: which mode, how many samples in/out so far.
    bit            m_filling = 1'b1;
    int            m_wcnt = 0;
    int            m_rcnt = 0;
    logic [DW-1:0] m_frame [N];
    logic [DW-1:0] m_rddata = '0;
    bit            m_rdvalid = 0, m_rdlast = 0, m_drained = 0, m_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int addr_of(input int k);
        int r = 0;
`ifdef WINDOW_BUFFER_BITREV_EN
        for (int b = 0; b < LOGN; b++) begin
            if (((k >> b) & 1) != 0) r += 1 << (LOGN - 1 - b);
        end
`else
        r = k;
`endif
        return r;
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_filling = 1'b1;
            m_wcnt    = 0;
            m_rcnt    = 0;
            m_rdvalid = 0;
            m_rdlast  = 0;
            m_drained = 0;
            m_ovf     = 0;
            m_rddata  = '0;
        end else begin
            m_drained = m_rdlast;
            m_rdvalid = 0;
            m_rdlast  = 0;
            if (m_filling) begin
                if (wren) begin
                    m_frame[m_wcnt] = wrdata;
                    m_wcnt++;
                    if (m_wcnt == N) begin
                        m_filling = 1'b0;
                        m_wcnt    = 0;
                    end
                end
            end else begin
                if (wren) m_ovf = 1;
                if (rden) begin
                    m_rdvalid = 1;
                    m_rddata  = m_frame[addr_of(m_rcnt)];
                    m_rdlast  = (m_rcnt == N - 1);
                    m_rcnt++;
                    if (m_rcnt == N) begin
                        m_filling = 1'b1;
                        m_rcnt    = 0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_rdvalid", 32'(rdvalid), 32'(m_rdvalid));
            chk("model_rdlast", 32'(rdlast), 32'(m_rdlast));
            chk("model_full", 32'(full), 32'(!m_filling));
            chk("model_drained", 32'(drained), 32'(m_drained));
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
            chk("model_rddata", 32'(rddata), 32'(m_rddata));
        end
    end

    task automatic fill(input int base, input int gap);
        for (int i = 0; i < N; i++) begin
            for (int g = 1; g < gap; g++) begin
                wren = 1'b0;
                step();
                chk("fill_full_low", 32'(full), 32'd0);
            end
            wren   = 1'b1;
            wrdata = DW'(base + i);
            chk("fill_full_pre", 32'(full), 32'd0);
            step();
        end
        wren = 1'b0;
        chk("fill_full_rise", 32'(full), 32'd1);
    endtask

    task automatic drain(input int base, input int pause_at, input int pause_len, input bit inj);
        int got [$];
        int last_idx = -1;
        int gap = 0;
        int paused = 0;
        bit injd = 0;
        bit done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            wren = 1'b0;
            if (got.size() == pause_at && paused < pause_len) begin
                rden = 1'b0;
                paused++;
            end else begin
                rden = 1'b1;
            end
            if (inj && got.size() == 2 && !injd) begin
                wren   = 1'b1;
                wrdata = 14'h1FFF;
                injd   = 1;
            end
            step();
            if (rdvalid) begin
                got.push_back(int'(rddata));
                if (rdlast) last_idx = got.size() - 1;
            end else if (pause_len > 0 && got.size() == pause_at) begin
                gap++;
            end
            if (drained) begin
                done = 1;
                chk("drained_full_low", 32'(full), 32'd0);
            end
        end
        rden = 1'b0;
        wren = 1'b0;
        chk("drain_completed", 32'(done), 32'd1);
        chk("drain_count", 32'(got.size()), 32'(N));
        for (int k = 0; k < N && k < got.size(); k++) begin
            chk("drain_data", 32'(got[k]), 32'(base + lit[k]));
        end
        chk("drain_rdlast_pos", 32'(last_idx), 32'(N - 1));
        if (pause_len > 0) chk("drain_gap", 32'(gap), 32'(pause_len));
    endtask

    initial begin
`ifdef WINDOW_BUFFER_BITREV_EN
        lit = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        lit = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        rst_n  = 1'b0;
        wren   = 1'b0;
        rden   = 1'b0;
        wrdata = '0;
        step();
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_rdvalid", 32'(rdvalid), 32'd0);
        chk("reset_rddata", 32'(rddata), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);

        // Fill then drain, rden high throughout the fill (must be ignored).
        rden = 1'b1;
        fill(0, 1);
        drain(0, -1, 0, 0);

        // Gapped input, every third cycle.
        fill(20, 3);
        drain(20, -1, 0, 0);

        // Pause drain after 3 reads for 3 cycles.
        fill(30, 1);
        drain(30, 3, 3, 0);

        // Overflow: write during drain.
        fill(100, 1);
        drain(100, -1, 0, 1);
        chk("overflow_set", 32'(overflow), 32'd1);
        fill(40, 1);
        drain(40, -1, 0, 0);
        chk("overflow_sticky", 32'(overflow), 32'd1);

        // Reset mid-drain after 4 reads, with strobes active in the reset cycle.
        fill(50, 1);
        rden = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        wren  = 1'b1;
        step();
        chk("rst_mid_rdvalid", 32'(rdvalid), 32'd0);
        chk("rst_mid_full", 32'(full), 32'd0);
        chk("rst_mid_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        wren  = 1'b0;
        rden  = 1'b0;
        step();
        fill(10, 1);
        drain(10, -1, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            wren   = ($urandom_range(0, 2) != 0);
            rden   = ($urandom_range(0, 3) != 0);
            wrdata = DW'($urandom);
            rst_n  = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_n = 1'b1;
        wren  = 1'b0;
        rden  = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
